// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state encoding and SPI mode constants for spi_controller
// Purpose: single home for the controller FSM encoding and the supported SPI mode.
// Contents:
//   spi_ctrl_state_t  FSM state encoding (IDLE, SETUP, SHIFT, HOLD, LINGER)
//   CPOL, CPHA        the only supported mode (mode 0)
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    SHIFT  = 3'd2,
    HOLD   = 3'd3,
    LINGER = 3'd4
  } spi_ctrl_state_t;

  localparam logic CPOL = 1'b0;
  localparam logic CPHA = 1'b0;

endpackage

// File: rtl/spi_clk_gen.sv
// rtl/spi_clk_gen.sv - sck divider with rising/falling strobes for spi_controller
// Purpose: derives sck from the system clock while enabled; sck idles at CPOL.
// Ports:
//   i_clk       in   system clock
//   i_rst       in   synchronous active-high reset
//   i_en        in   run the divider; low forces the divider to 0 and sck to idle
//   o_sck       out  registered SPI clock
//   o_rise_stb  out  high in the cycle whose closing edge drives sck high
//   o_fall_stb  out  high in the cycle whose closing edge drives sck low
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  output logic o_sck,
  output logic o_rise_stb,
  output logic o_fall_stb
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_cnt;
  logic             r_sck;
  logic             w_toggle;

  // Strobes are combinational so the controller acts on the same edge that
  // moves sck; miso is therefore captured exactly when sck goes high.
  assign w_toggle   = i_en && (r_cnt == DIV_LAST);
  assign o_rise_stb = w_toggle && (r_sck == CPOL);
  assign o_fall_stb = w_toggle && (r_sck != CPOL);
  assign o_sck      = r_sck;

  // Holding the divider clear while disabled makes every enable start a fresh
  // CLK_DIV-long low half-period.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_en) begin
      r_cnt <= '0;
      r_sck <= CPOL;
    end else if (w_toggle) begin
      r_cnt <= '0;
      r_sck <= ~r_sck;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_controller.sv
// rtl/spi_controller.sv - SPI mode-0 controller, MSB first, with optional burst
// Purpose: drives sck/ss/mosi and samples miso; start/busy/done handshake.
// Ports:
//   i_clk    in   system clock
//   i_rst    in   synchronous active-high reset
//   i_start  in   transfer request, taken in IDLE or LINGER
//   i_burst  in   sampled with start; 1 keeps ss low after the word
//   i_din    in   word to send, sampled on the accept edge
//   o_busy   out  high from accept until the word ends
//   o_done   out  one-cycle pulse when a word completes
//   o_dout   out  received word, updated with done
//   o_sck    out  SPI clock, idle low
//   o_ss     out  slave select, active low
//   o_mosi   out  serial data out
//   i_miso   in   serial data in
module spi_controller
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4,
  parameter int SS_SETUP   = 2,
  parameter int SS_HOLD    = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_burst,
  input  logic [DATA_WIDTH-1:0] i_din,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_dout,
  output logic                  o_sck,
  output logic                  o_ss,
  output logic                  o_mosi,
  input  logic                  i_miso
);

  if (DATA_WIDTH < 2) begin : g_bad_width
    $error("spi_controller: DATA_WIDTH must be >= 2");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $error("spi_controller: CLK_DIV must be >= 1");
  end
  if (CPOL != 1'b0 || CPHA != 1'b0) begin : g_bad_mode
    $error("spi_controller: only SPI mode 0 is implemented");
  end

  localparam logic [2:0] ST_IDLE   = 3'(IDLE);
  localparam logic [2:0] ST_SETUP  = 3'(SETUP);
  localparam logic [2:0] ST_SHIFT  = 3'(SHIFT);
  localparam logic [2:0] ST_HOLD   = 3'(HOLD);
  localparam logic [2:0] ST_LINGER = 3'(LINGER);

  // One counter serves both SETUP and HOLD; a zero-length phase still lasts one cycle.
  localparam int SH_MAX     = (SS_SETUP > SS_HOLD) ? SS_SETUP : SS_HOLD;
  localparam int CNT_W      = (SH_MAX > 1) ? $clog2(SH_MAX) : 1;
  localparam int SETUP_LAST = (SS_SETUP > 0) ? SS_SETUP - 1 : 0;
  localparam int HOLD_LAST  = (SS_HOLD > 0) ? SS_HOLD - 1 : 0;
  localparam int BC_W       = $clog2(DATA_WIDTH + 1);
  localparam logic [BC_W-1:0] BIT_LAST = BC_W'(DATA_WIDTH - 1);

  logic [2:0]            r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [BC_W-1:0]       r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shreg;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_sample;
  logic                  r_burst;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_ss;
  logic                  r_mosi;

  logic w_accept;
  logic w_rise;
  logic w_fall;
  logic w_shift_en;

  assign w_shift_en = (r_state == ST_SHIFT);

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_en       (w_shift_en),
    .o_sck      (o_sck),
    .o_rise_stb (w_rise),
    .o_fall_stb (w_fall)
  );

  // The done cycle of a burst word is already LINGER; gating on r_done keeps a
  // start coinciding with done from being taken.
  assign w_accept = i_start && !r_done && ((r_state == ST_IDLE) || (r_state == ST_LINGER));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_bit_cnt <= '0;
      r_shreg   <= '0;
      r_dout    <= '0;
      r_sample  <= 1'b0;
      r_burst   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ss      <= 1'b1;
      r_mosi    <= 1'b0;
    end else begin
      r_done <= 1'b0;

      // miso is parked in r_sample until the following fall, because the
      // shift register LSB still holds an untransmitted bit at the first rise.
      if (w_rise) begin
        r_sample <= i_miso;
      end

      if (w_accept) begin
        r_shreg   <= i_din;
        r_mosi    <= i_din[DATA_WIDTH-1];
        r_burst   <= i_burst;
        r_busy    <= 1'b1;
        r_bit_cnt <= '0;
        r_cnt     <= '0;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_ss    <= 1'b0;
            r_state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (r_cnt == CNT_W'(SETUP_LAST)) begin
            r_cnt   <= '0;
            r_state <= ST_SHIFT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_SHIFT: begin
          if (w_fall) begin
            r_shreg <= {r_shreg[DATA_WIDTH-2:0], r_sample};
            if (r_bit_cnt == BIT_LAST) begin
              r_dout  <= {r_shreg[DATA_WIDTH-2:0], r_sample};
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_cnt   <= '0;
              r_state <= r_burst ? ST_LINGER : ST_HOLD;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_mosi    <= r_shreg[DATA_WIDTH-2];
            end
          end
        end
        ST_HOLD: begin
          if (r_cnt == CNT_W'(HOLD_LAST)) begin
            r_ss    <= 1'b1;
            r_mosi  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_LINGER: begin
          if (w_accept) begin
            r_state <= ST_SHIFT;
          end else if (!i_start && !i_burst) begin
            r_cnt   <= '0;
            r_state <= ST_HOLD;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_dout = r_dout;
  assign o_ss   = r_ss;
  assign o_mosi = r_mosi;

endmodule
